// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared CPU defines for the pipeline hazard controller.
//   mem_state_e : encoding of the data-memory handshake FSM
//   REG_X0      : address of the hard-wired zero register
package pipe_hazard_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage : pipe_hazard_ctrl_pkg

// File: rtl/pipe_mem_fsm.sv
// Data-memory handshake FSM.
// Tracks whether the access in M is still waiting for the data memory and
// produces the request and the memory stall condition.
// Ports:
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   mem_op_i       : a load or store sits in M
//   dmem_ready_i   : data memory completes the current access
//   dmem_req_o     : data memory request (combinational)
//   mem_stall_o    : pipeline must hold while the access is outstanding
module pipe_mem_fsm
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic mem_op_i,
  input  logic dmem_ready_i,
  output logic dmem_req_o,
  output logic mem_stall_o
);

  mem_state_e state_q, state_d;

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  // Reset drops any pending access: the FSM restarts in IDLE.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    dmem_req_o  = 1'b0;
    mem_stall_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        dmem_req_o  = mem_op_i;
        // A ready in the same cycle as the request costs no stall cycle.
        mem_stall_o = mem_op_i & ~dmem_ready_i;
        if (mem_op_i && !dmem_ready_i) state_d = WAIT;
      end
      WAIT: begin
        dmem_req_o  = 1'b1;
        mem_stall_o = ~dmem_ready_i;
        if (dmem_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule : pipe_mem_fsm

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller for a five-stage F/D/E/M/W pipeline.
// Resolves data-memory stalls, taken-branch flushes and load-use hazards
// into hold (stall) and clear (bubble) controls for the stage registers,
// and counts cycles in which fetch is held.
// Ports:
//   clk_i, rst_n_i              : clock, asynchronous active-low reset
//   D_rs1/rs2_addr_i, _used_i   : sources read by the instruction in D
//   E_reg_waddr_i/_wen_i/_mux_i : destination of the instruction in E (mux=1: load)
//   E_branch_taken_i            : taken branch/jump resolved in E
//   M_mem_wen_i, M_reg_mux_i    : store / load in M
//   dmem_ready_i, dmem_req_o    : data memory handshake
//   *_stall_o, *_bubble_o       : stage register hold / clear controls
//   stall_cycles_o              : saturating count of fetch-stall cycles
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [4:0]       D_rs1_addr_i,
  input  logic [4:0]       D_rs2_addr_i,
  input  logic             D_rs1_used_i,
  input  logic             D_rs2_used_i,
  input  logic [4:0]       E_reg_waddr_i,
  input  logic             E_reg_wen_i,
  input  logic             E_reg_mux_i,
  input  logic             E_branch_taken_i,
  input  logic             M_mem_wen_i,
  input  logic             M_reg_mux_i,
  input  logic             dmem_ready_i,
  output logic             dmem_req_o,
  output logic             F_stall_o,
  output logic             D_stall_o,
  output logic             D_bubble_o,
  output logic             E_stall_o,
  output logic             E_bubble_o,
  output logic             M_stall_o,
  output logic             M_bubble_o,
  output logic             W_bubble_o,
  output logic [CNT_W-1:0] stall_cycles_o
);

  logic mem_op;
  logic mem_stall;
  logic load_use;

  assign mem_op = M_mem_wen_i | M_reg_mux_i;

  pipe_mem_fsm u_mem_fsm (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .mem_op_i     (mem_op),
    .dmem_ready_i (dmem_ready_i),
    .dmem_req_o   (dmem_req_o),
    .mem_stall_o  (mem_stall)
  );

  // A load in E whose destination a source of D needs; x0 never creates
  // a dependency because it is never written.
  assign load_use = E_reg_mux_i & E_reg_wen_i & (E_reg_waddr_i != REG_X0) &
                    ((D_rs1_used_i & (D_rs1_addr_i == E_reg_waddr_i)) |
                     (D_rs2_used_i & (D_rs2_addr_i == E_reg_waddr_i)));

  // Priority: memory stall freezes everything; a taken branch discards D,
  // which makes any load-use on that D instruction irrelevant.
  always_comb begin
    F_stall_o  = 1'b0;
    D_stall_o  = 1'b0;
    D_bubble_o = 1'b0;
    E_stall_o  = 1'b0;
    E_bubble_o = 1'b0;
    M_stall_o  = 1'b0;
    M_bubble_o = 1'b0;
    W_bubble_o = 1'b0;
    if (mem_stall) begin
      F_stall_o  = 1'b1;
      D_stall_o  = 1'b1;
      E_stall_o  = 1'b1;
      M_stall_o  = 1'b1;
      W_bubble_o = 1'b1;
    end else if (E_branch_taken_i) begin
      // Fetch keeps running so the branch target enters F.
      D_bubble_o = 1'b1;
      E_bubble_o = 1'b1;
    end else if (load_use) begin
      F_stall_o  = 1'b1;
      D_stall_o  = 1'b1;
      E_bubble_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cycles_o <= '0;
    end else if (F_stall_o && (stall_cycles_o != {CNT_W{1'b1}})) begin
      stall_cycles_o <= stall_cycles_o + CNT_W'(1);
    end
  end

endmodule : pipe_hazard_ctrl
